// File: rtl/jtdsp16_pkg.sv
// Shared constants for the DSP16 internal ROM and its loader.
package jtdsp16_pkg;

  // Address width of the internal program ROM (8kB image).
  localparam int ROM_AW = 13;

  // Loader state encoding.
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/jtdsp16_rom_loader.sv
// Streams a ROM image (valid/ready bytes) into the DSP16 ROM programming port.
// Bytes are written in arrival order, LSB at even address. The loader also keeps
// a running 16-bit additive checksum and a stall watchdog, and reports done/err.
module jtdsp16_rom_loader
  import jtdsp16_pkg::*;
#(
  parameter int AW     = ROM_AW,
  parameter int TOUT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   exp_csum,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic [AW-1:0] prog_addr,
  output logic [7:0]    prog_data,
  output logic          prog_we,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   csum
);

  ld_state_t         state;
  logic [AW-1:0]     cnt;
  logic [TOUT_W-1:0] idle_cnt;
  logic              accept;
  logic              last;
  logic              timeout;
  logic [15:0]       csum_next;

  // Start and abort take the whole cycle, so no byte is taken alongside them.
  assign s_ready   = (state == LD_LOAD) && !start && !abort;
  assign accept    = s_valid && s_ready;
  assign last      = (cnt == {AW{1'b1}});
  assign csum_next = csum + {8'd0, s_data};

  // The counter reaches all-ones on the edge that ends the stalled cycle, so
  // flag the timeout one count early to retire LOAD on that same edge.
  assign timeout = s_ready && !s_valid &&
                   (idle_cnt == {{(TOUT_W-1){1'b1}}, 1'b0});

  // Stall watchdog: counts LOAD cycles with no accepted byte.
  // NOTE: asynchronous reset only on control/state registers; there is no memory here to reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (start || accept) begin
      idle_cnt <= '0;
    end else if (state == LD_LOAD) begin
      idle_cnt <= idle_cnt + TOUT_W'(1);
    end
  end

  // Load FSM with registered programming-port and status outputs.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LD_IDLE;
      cnt       <= '0;
      csum      <= '0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      if (abort) begin
        state <= LD_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        state <= LD_LOAD;
        busy  <= 1'b1;
        done  <= 1'b0;
        err   <= 1'b0;
        cnt   <= '0;
        csum  <= '0;
      end else begin
        case (state)
          LD_LOAD: begin
            if (accept) begin
              prog_addr <= cnt;
              prog_data <= s_data;
              prog_we   <= 1'b1;
              cnt       <= cnt + AW'(1);
              csum      <= csum_next;
              if (last) begin
                state <= LD_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
                if (csum_next != exp_csum) err <= 1'b1;
              end
            end else if (timeout) begin
              state <= LD_IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          default: begin
            // A byte offered outside LOAD is dropped and flagged.
            if (s_valid) err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// Self-checking bench for jtdsp16_rom_loader: directed phases with random data,
// checked against a transaction-level model of the loader.
module tb_jtdsp16_rom_loader;

  localparam int AW   = 13;
  localparam int NB   = 1 << AW;
  localparam int TMAX = (1 << 16) - 1;
  localparam logic [31:0] NO_WRITE = 32'hDEAD_BEEF;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   exp_csum = 16'd0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_ready;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          prog_we;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   csum;

  always #5 clk = ~clk;

  jtdsp16_rom_loader #(.AW(AW), .TOUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .exp_csum  (exp_csum),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .csum      (csum)
  );

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  // Expected writes as {addr, data}, in order.
  logic [31:0] exp_q[$];

  // Behavioural model of the loader.
  int m_state = M_IDLE;
  int m_cnt   = 0;
  int m_sum   = 0;
  int m_idle  = 0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every programming-port write must be the next one the model predicted.
  always @(negedge clk) begin
    if (rst_n && prog_we) begin
      logic [31:0] expw;
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : NO_WRITE;
      wr_count++;
      check("prog_write", {11'd0, prog_addr, prog_data}, expw);
    end
  end

  // One clock of stimulus; the model applies the loader's rules to the same inputs.
  task automatic cycle(input logic v, input logic [7:0] d, input logic st, input logic ab);
    bit exp_ready;
    s_valid = v;
    s_data  = d;
    start   = st;
    abort   = ab;
    exp_ready = (m_state == M_LOAD) && !st && !ab;
    #1;
    check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
    if (ab) begin
      m_state = M_IDLE;
      m_done  = 1'b0;
    end else if (st) begin
      m_state = M_LOAD;
      m_cnt   = 0;
      m_sum   = 0;
      m_idle  = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
    end else if (m_state != M_LOAD) begin
      if (v) m_err = 1'b1;
    end else if (v) begin
      exp_q.push_back({11'd0, m_cnt[AW-1:0], d});
      m_sum  = (m_sum + int'(d)) % 65536;
      m_idle = 0;
      if (m_cnt == NB - 1) begin
        m_state = M_DONE;
        m_done  = 1'b1;
        if (m_sum != int'(exp_csum)) m_err = 1'b1;
      end
      m_cnt = (m_cnt + 1) % NB;
    end else begin
      m_idle++;
      if (m_idle == TMAX) begin
        m_state = M_IDLE;
        m_err   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_state == M_LOAD)});
    check({tag, "_done"}, {31'd0, done}, {31'd0, m_done});
    check({tag, "_err"},  {31'd0, err},  {31'd0, m_err});
    check({tag, "_csum"}, {16'd0, csum}, m_sum);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, {19'd0, prog_addr}, 0);
    check({tag, "_data"}, {24'd0, prog_data}, 0);
    check({tag, "_we"},   {31'd0, prog_we}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_err"},  {31'd0, err}, 0);
    check({tag, "_csum"}, {16'd0, csum}, 0);
    check({tag, "_ready"}, {31'd0, s_ready}, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stray byte in IDLE: flagged, never written.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("stray_idle");

    // Full load with correct checksum; the byte offered with start is refused.
    exp_csum = 16'hF000;
    wr_count = 0;
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < NB; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("full_good");
    check("full_good_writes", wr_count, NB);
    check("full_good_csum_const", {16'd0, csum}, 32'h0000_F000);

    // Stray byte in DONE.
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("stray_done");

    // Full load with wrong expected checksum.
    exp_csum = 16'h0000;
    wr_count = 0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < NB; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("full_bad");
    check("full_bad_writes", wr_count, NB);

    // Gapped random stream, then abort with a byte offered in the abort cycle.
    exp_csum = 16'($urandom);
    wr_count = 0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 5)) cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("gap_abort");
    check("gap_abort_writes", wr_count, 100);

    // Stall timeout: one idle cycle short still loading, then timed out.
    wr_count = 0;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (TMAX - 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("timeout_minus1");
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("timeout");
    check("timeout_writes", wr_count, 10);

    // Reset mid-load clears everything asynchronously.
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 500; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_status("preload_reset");
    check("preload_reset_addr", {19'd0, prog_addr}, 499);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    m_state = M_IDLE;
    m_cnt   = 0;
    m_sum   = 0;
    m_idle  = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
